// File: rtl/conv_pkg.sv
// Layer table shared by the convolution output path and Conv_Control:
// layer-state codes, plane sizes, derived last addresses, loop/filter counts.
package conv_pkg;

   localparam int STATE_W  = 4;
   localparam int ADDR_W   = 13;
   localparam int LOOP_W   = 3;
   localparam int FILTER_W = 5;

   localparam logic [STATE_W-1:0] CONV1_1 = 4'd2;
   localparam logic [STATE_W-1:0] CONV1_2 = 4'd3;
   localparam logic [STATE_W-1:0] CONV2_1 = 4'd5;
   localparam logic [STATE_W-1:0] CONV2_2 = 4'd6;
   localparam logic [STATE_W-1:0] CONV3_1 = 4'd8;
   localparam logic [STATE_W-1:0] CONV3_2 = 4'd9;

   localparam int CONV1_1_SIZE = 82;
   localparam int CONV1_2_SIZE = 80;
   localparam int CONV2_1_SIZE = 38;
   localparam int CONV2_2_SIZE = 36;
   localparam int CONV3_1_SIZE = 16;
   localparam int CONV3_2_SIZE = 14;

   // Last addresses are elaboration-time constants so no multiplier is built.
   localparam logic [ADDR_W-1:0] CONV1_1_LAST = ADDR_W'(CONV1_1_SIZE * CONV1_1_SIZE - 1);
   localparam logic [ADDR_W-1:0] CONV1_2_LAST = ADDR_W'(CONV1_2_SIZE * CONV1_2_SIZE - 1);
   localparam logic [ADDR_W-1:0] CONV2_1_LAST = ADDR_W'(CONV2_1_SIZE * CONV2_1_SIZE - 1);
   localparam logic [ADDR_W-1:0] CONV2_2_LAST = ADDR_W'(CONV2_2_SIZE * CONV2_2_SIZE - 1);
   localparam logic [ADDR_W-1:0] CONV3_1_LAST = ADDR_W'(CONV3_1_SIZE * CONV3_1_SIZE - 1);
   localparam logic [ADDR_W-1:0] CONV3_2_LAST = ADDR_W'(CONV3_2_SIZE * CONV3_2_SIZE - 1);

   localparam int CONV1_1_LOOPS = 1;
   localparam int CONV1_2_LOOPS = 2;
   localparam int CONV2_1_LOOPS = 2;
   localparam int CONV2_2_LOOPS = 4;
   localparam int CONV3_1_LOOPS = 4;
   localparam int CONV3_2_LOOPS = 4;

   localparam int CONV1_1_FILTERS = 6;
   localparam int CONV1_2_FILTERS = 6;
   localparam int CONV2_1_FILTERS = 16;
   localparam int CONV2_2_FILTERS = 16;
   localparam int CONV3_1_FILTERS = 16;
   localparam int CONV3_2_FILTERS = 16;

   typedef enum logic [1:0] {
      GEN_IDLE,
      GEN_RUN,
      GEN_DONE
   } gen_state_t;

   typedef struct packed {
      logic                is_conv;
      logic [ADDR_W-1:0]   last_addr;
      logic [LOOP_W-1:0]   last_loop;
      logic [FILTER_W-1:0] last_filter;
   } layer_cfg_t;

   function automatic layer_cfg_t layer_lookup(input logic [STATE_W-1:0] st);
      layer_cfg_t cfg;
      cfg = '0;
      case (st)
         CONV1_1: cfg = '{1'b1, CONV1_1_LAST, LOOP_W'(CONV1_1_LOOPS - 1), FILTER_W'(CONV1_1_FILTERS - 1)};
         CONV1_2: cfg = '{1'b1, CONV1_2_LAST, LOOP_W'(CONV1_2_LOOPS - 1), FILTER_W'(CONV1_2_FILTERS - 1)};
         CONV2_1: cfg = '{1'b1, CONV2_1_LAST, LOOP_W'(CONV2_1_LOOPS - 1), FILTER_W'(CONV2_1_FILTERS - 1)};
         CONV2_2: cfg = '{1'b1, CONV2_2_LAST, LOOP_W'(CONV2_2_LOOPS - 1), FILTER_W'(CONV2_2_FILTERS - 1)};
         CONV3_1: cfg = '{1'b1, CONV3_1_LAST, LOOP_W'(CONV3_1_LOOPS - 1), FILTER_W'(CONV3_1_FILTERS - 1)};
         CONV3_2: cfg = '{1'b1, CONV3_2_LAST, LOOP_W'(CONV3_2_LOOPS - 1), FILTER_W'(CONV3_2_FILTERS - 1)};
         default: cfg = '0;
      endcase
      return cfg;
   endfunction

endpackage

// File: rtl/conv_out_addr_gen_if.sv
// Partial-sum stream in, output-buffer write bus out. out_ready/ps_ready
// only exist when CONV_ADDR_BACKPRESSURE_EN is defined.
interface conv_out_if #(
   parameter int DATA_WIDTH        = 16,
   parameter int ADDRESS_DATAWIDTH = 13
);

   logic                         ps_valid;
   logic [DATA_WIDTH-1:0]        ps_data;
`ifdef CONV_ADDR_BACKPRESSURE_EN
   logic                         out_ready;
   logic                         ps_ready;
`endif
   logic [ADDRESS_DATAWIDTH-1:0] Out_Address;
   logic                         wr_en;
   logic [DATA_WIDTH-1:0]        wr_data;
   logic                         acc_en;
   logic                         plane_end;
   logic                         layer_done;

   // The address generator is the slave of the partial-sum stream.
   modport slave (
      input  ps_valid,
      input  ps_data,
`ifdef CONV_ADDR_BACKPRESSURE_EN
      input  out_ready,
      output ps_ready,
`endif
      output Out_Address,
      output wr_en,
      output wr_data,
      output acc_en,
      output plane_end,
      output layer_done
   );

   modport master (
      output ps_valid,
      output ps_data,
`ifdef CONV_ADDR_BACKPRESSURE_EN
      output out_ready,
      input  ps_ready,
`endif
      input  Out_Address,
      input  wr_en,
      input  wr_data,
      input  acc_en,
      input  plane_end,
      input  layer_done
   );

endinterface

// File: rtl/conv_out_addr_gen_plane_counter.sv
// Output-plane address counter: clear, count enable and wrap at a
// runtime-selected terminal value.
module plane_counter #(
   parameter int WIDTH = 13
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   input  logic [WIDTH-1:0] last_value,
   output logic [WIDTH-1:0] count,
   output logic             at_last
);

   assign at_last = (count == last_value);

   always_ff @(posedge clk) begin
      if (!reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= at_last ? '0 : count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/conv_out_addr_gen.sv
// Output-address generator for the conv output feature-map buffer.
// Define CONV_ADDR_BACKPRESSURE_EN to add out_ready/ps_ready flow control.
module conv_out_addr_gen
   import conv_pkg::*;
#(
   parameter int DATA_WIDTH        = 16,
   parameter int STATE_DATAWIDTH   = 4,
   parameter int ADDRESS_DATAWIDTH = 13,
   parameter int LOOP_DATAWIDTH    = 3,
   parameter int FILTER_DATAWIDTH  = 5
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [STATE_DATAWIDTH-1:0]  state,
   conv_out_if.slave                   bus,
   output logic [LOOP_DATAWIDTH-1:0]   loop_cnt,
   output logic [FILTER_DATAWIDTH-1:0] filter_cnt,
   output logic                        err_overrun
);

   layer_cfg_t                   cfg;
   logic [ADDRESS_DATAWIDTH-1:0] last_addr;
   logic [STATE_DATAWIDTH-1:0]   state_q;
   logic                         state_changed;
   gen_state_t                   gen_q;
   gen_state_t                   gen_d;
   logic                         word_ok;
   logic                         accept;
   logic                         clear_cnt;
   logic [ADDRESS_DATAWIDTH-1:0] addr;
   logic                         at_last;
   logic                         last_loop;
   logic                         last_filter;
   logic                         layer_end;

   logic [ADDRESS_DATAWIDTH-1:0] out_address_q;
   logic                         wr_en_q;
   logic [DATA_WIDTH-1:0]        wr_data_q;
   logic                         acc_en_q;
   logic                         plane_end_q;
   logic                         layer_done_q;

   assign cfg           = layer_lookup(STATE_W'(state));
   assign last_addr     = ADDRESS_DATAWIDTH'(cfg.last_addr);
   assign state_changed = (state != state_q);
   assign last_loop     = (loop_cnt == LOOP_DATAWIDTH'(cfg.last_loop));
   assign last_filter   = (filter_cnt == FILTER_DATAWIDTH'(cfg.last_filter));
   assign layer_end     = at_last && last_loop && last_filter;

`ifdef CONV_ADDR_BACKPRESSURE_EN
   assign word_ok      = bus.ps_valid && bus.out_ready;
   assign bus.ps_ready = bus.out_ready && (gen_q == GEN_RUN);
`else
   assign word_ok = bus.ps_valid;
`endif

   // state_q resets to an IDLE code so a conv state present at reset release
   // is seen as a fresh layer.
   always_ff @(posedge clk) begin
      if (!reset) begin
         gen_q   <= GEN_IDLE;
         state_q <= '0;
      end else begin
         gen_q   <= gen_d;
         state_q <= state;
      end
   end

   // A layer-state change always wins: counters restart and any word offered
   // in the same cycle is dropped.
   always_comb begin
      gen_d     = gen_q;
      accept    = 1'b0;
      clear_cnt = 1'b0;
      if (state_changed) begin
         clear_cnt = 1'b1;
         gen_d     = cfg.is_conv ? GEN_RUN : GEN_IDLE;
      end else begin
         case (gen_q)
            GEN_IDLE: gen_d = GEN_IDLE;
            GEN_RUN: begin
               accept = word_ok;
               if (word_ok && layer_end) begin
                  gen_d = GEN_DONE;
               end
            end
            GEN_DONE: gen_d = GEN_DONE;
            default:  gen_d = GEN_IDLE;
         endcase
      end
   end

   plane_counter #(
      .WIDTH (ADDRESS_DATAWIDTH)
   ) u_plane_counter (
      .clk        (clk),
      .reset      (reset),
      .clear      (clear_cnt),
      .enable     (accept),
      .last_value (last_addr),
      .count      (addr),
      .at_last    (at_last)
   );

   // Loop index advances on every plane wrap; filter index on the last loop.
   always_ff @(posedge clk) begin
      if (!reset) begin
         loop_cnt   <= '0;
         filter_cnt <= '0;
      end else if (clear_cnt) begin
         loop_cnt   <= '0;
         filter_cnt <= '0;
      end else if (accept && at_last) begin
         if (last_loop) begin
            loop_cnt   <= '0;
            filter_cnt <= last_filter ? '0 : filter_cnt + FILTER_DATAWIDTH'(1);
         end else begin
            loop_cnt <= loop_cnt + LOOP_DATAWIDTH'(1);
         end
      end
   end

   // Write-side registers hold their last value between accepted words.
   always_ff @(posedge clk) begin
      if (!reset) begin
         out_address_q <= '0;
         wr_en_q       <= 1'b0;
         wr_data_q     <= '0;
         acc_en_q      <= 1'b0;
         plane_end_q   <= 1'b0;
         layer_done_q  <= 1'b0;
         err_overrun   <= 1'b0;
      end else begin
         wr_en_q      <= accept;
         plane_end_q  <= accept && at_last;
         layer_done_q <= accept && layer_end;
         if (accept) begin
            out_address_q <= addr;
            wr_data_q     <= bus.ps_data;
            acc_en_q      <= (loop_cnt != '0);
         end
         if ((gen_q == GEN_DONE) && !state_changed && bus.ps_valid) begin
            err_overrun <= 1'b1;
         end
      end
   end

   assign bus.Out_Address = out_address_q;
   assign bus.wr_en       = wr_en_q;
   assign bus.wr_data     = wr_data_q;
   assign bus.acc_en      = acc_en_q;
   assign bus.plane_end   = plane_end_q;
   assign bus.layer_done  = layer_done_q;

endmodule

// File: tb/tb_conv_out_addr_gen.sv
// Self-checking bench for conv_out_addr_gen: vector table, directed layer
// runs and a randomized phase against a linear word-index reference model.
`timescale 1ns/1ps
module tb_conv_out_addr_gen;

`ifdef CONV_ADDR_BACKPRESSURE_EN
   localparam bit BP = 1'b1;
`else
   localparam bit BP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  state;
   logic [2:0]  loop_cnt;
   logic [4:0]  filter_cnt;
   logic        err_overrun;
   logic        rdy;

   always #5 clk = ~clk;

   conv_out_if #(.DATA_WIDTH(16), .ADDRESS_DATAWIDTH(13)) bus ();

`ifdef CONV_ADDR_BACKPRESSURE_EN
   assign bus.out_ready = rdy;
`endif

   conv_out_addr_gen dut (
      .clk         (clk),
      .reset       (reset),
      .state       (state),
      .bus         (bus),
      .loop_cnt    (loop_cnt),
      .filter_cnt  (filter_cnt),
      .err_overrun (err_overrun)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: position is one linear word index within the layer.
   int          m_prev, m_mode, m_k;
   bit          m_err;
   logic [12:0] e_addr;
   logic [15:0] e_data;
   logic        e_wr, e_acc, e_pe, e_ld;
   logic [2:0]  e_loop;
   logic [4:0]  e_filt;

   int wr_cnt, acc_cnt, pe_cnt, ld_cnt, ld_word;
   bit ld_pe;

   typedef struct {
      bit          rst_n;
      int          st;
      bit          v;
      logic [12:0] addr;
      logic        wr;
      logic        acc;
      logic [2:0]  loop_i;
      logic [4:0]  filt;
      logic        pe;
      logic        ld;
      logic        err;
   } vec_t;

   vec_t vecs[10];

   function automatic void layer_info(input int st, output int sz, output int lp, output int fl);
      sz = 0; lp = 1; fl = 1;
      case (st)
         2: begin sz = 82; lp = 1; fl = 6;  end
         3: begin sz = 80; lp = 2; fl = 6;  end
         5: begin sz = 38; lp = 2; fl = 16; end
         6: begin sz = 36; lp = 4; fl = 16; end
         8: begin sz = 16; lp = 4; fl = 16; end
         9: begin sz = 14; lp = 4; fl = 16; end
         default: ;
      endcase
   endfunction

   task automatic model_step(input bit rst_n, input int st, input bit v, input logic [15:0] d, input bit r);
      int sz, lp, fl, plane, total;
      e_wr = 1'b0; e_pe = 1'b0; e_ld = 1'b0;
      if (!rst_n) begin
         m_prev = 0; m_mode = 0; m_k = 0; m_err = 1'b0;
         e_addr = '0; e_data = '0; e_acc = 1'b0;
      end else begin
         layer_info(st, sz, lp, fl);
         plane = sz * sz;
         total = plane * lp * fl;
         if (st != m_prev) begin
            m_mode = (sz != 0) ? 1 : 0;
            m_k = 0;
         end else if (m_mode == 1 && v && (BP ? r : 1'b1)) begin
            e_wr   = 1'b1;
            e_addr = 13'(m_k % plane);
            e_data = d;
            e_acc  = ((m_k / plane) % lp) != 0;
            e_pe   = (m_k % plane) == plane - 1;
            e_ld   = (m_k == total - 1);
            m_k++;
            if (m_k == total) begin
               m_mode = 2;
               m_k = 0;
            end
         end else if (m_mode == 2 && v) begin
            m_err = 1'b1;
         end
         m_prev = st;
      end
      if (m_mode == 1) begin
         e_loop = 3'((m_k / plane) % lp);
         e_filt = 5'(m_k / (plane * lp));
      end else begin
         e_loop = '0;
         e_filt = '0;
      end
   endtask

   task automatic checkOutput(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // One clock: drive, advance model, sample 1ns after the edge, compare.
   task automatic applyStimulus(input bit rst_n, input int st, input bit v, input logic [15:0] d, input bit r);
      logic [41:0] act, exp;
      reset = rst_n;
      state = st[3:0];
      bus.ps_valid = v;
      bus.ps_data = d;
      rdy = r;
      model_step(rst_n, st, v, d, r);
      @(posedge clk);
      #1;
      act = {bus.wr_en, bus.Out_Address, bus.wr_data, bus.acc_en, loop_cnt, filter_cnt,
             bus.plane_end, bus.layer_done, err_overrun};
      exp = {e_wr, e_addr, e_data, e_acc, e_loop, e_filt, e_pe, e_ld, m_err};
      checkOutput("model", longint'(act), longint'(exp));
`ifdef CONV_ADDR_BACKPRESSURE_EN
      checkOutput("ps_ready", longint'(bus.ps_ready), longint'(m_mode == 1 && r));
`endif
      if (bus.wr_en) begin
         wr_cnt++;
         if (bus.acc_en) acc_cnt++;
      end
      if (bus.plane_end) pe_cnt++;
      if (bus.layer_done) begin
         ld_cnt++;
         ld_word = wr_cnt;
         ld_pe = bus.plane_end;
      end
   endtask

   task automatic clearStats();
      wr_cnt = 0; acc_cnt = 0; pe_cnt = 0; ld_cnt = 0; ld_word = 0; ld_pe = 1'b0;
   endtask

   task automatic runWords(input int st, input int n, input bit toggle);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b1, st, 1'b1, 16'($urandom), 1'b1);
         if (toggle) applyStimulus(1'b1, st, 1'b0, 16'($urandom), 1'b1);
      end
   endtask

   initial begin
      logic [36:0] vact, vexp;
      int st_r;

      reset = 1'b0; state = '0; bus.ps_valid = 1'b0; bus.ps_data = '0; rdy = 1'b1;
      clearStats();

      //          rst st v  addr  wr acc loop filt pe ld err
      vecs[0] = '{0, 0, 0, 13'd0, 0, 0, 3'd0, 5'd0, 0, 0, 0};
      vecs[1] = '{1, 9, 1, 13'd0, 0, 0, 3'd0, 5'd0, 0, 0, 0};
      vecs[2] = '{1, 9, 1, 13'd0, 1, 0, 3'd0, 5'd0, 0, 0, 0};
      vecs[3] = '{1, 9, 0, 13'd0, 0, 0, 3'd0, 5'd0, 0, 0, 0};
      vecs[4] = '{1, 9, 1, 13'd1, 1, 0, 3'd0, 5'd0, 0, 0, 0};
      vecs[5] = '{1, 8, 1, 13'd1, 0, 0, 3'd0, 5'd0, 0, 0, 0};
      vecs[6] = '{1, 8, 1, 13'd0, 1, 0, 3'd0, 5'd0, 0, 0, 0};
      vecs[7] = '{1, 0, 1, 13'd0, 0, 0, 3'd0, 5'd0, 0, 0, 0};
      vecs[8] = '{1, 0, 1, 13'd0, 0, 0, 3'd0, 5'd0, 0, 0, 0};
      vecs[9] = '{0, 0, 0, 13'd0, 0, 0, 3'd0, 5'd0, 0, 0, 0};

      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i].rst_n, vecs[i].st, vecs[i].v, 16'($urandom), 1'b1);
         vact = {bus.Out_Address, bus.wr_en, bus.acc_en, loop_cnt, filter_cnt,
                 bus.plane_end, bus.layer_done, err_overrun, 11'd0};
         vexp = {vecs[i].addr, vecs[i].wr, vecs[i].acc, vecs[i].loop_i, vecs[i].filt,
                 vecs[i].pe, vecs[i].ld, vecs[i].err, 11'd0};
         checkOutput($sformatf("vec%0d", i), longint'(vact), longint'(vexp));
      end

      // Reset in the middle of a CONV2_1 plane.
      applyStimulus(1'b1, 5, 1'b0, 16'h0, 1'b1);
      runWords(5, 701, 1'b0);
      checkOutput("conv2_1_addr700", longint'(bus.Out_Address), 700);
      applyStimulus(1'b0, 5, 1'b1, 16'hBEEF, 1'b1);
      checkOutput("reset_all_zero",
                  longint'({bus.Out_Address, bus.wr_en, bus.wr_data, bus.acc_en, loop_cnt,
                            filter_cnt, bus.plane_end, bus.layer_done, err_overrun}), 0);
      applyStimulus(1'b1, 5, 1'b1, 16'h1234, 1'b1);
      checkOutput("post_reset_idle_no_write", longint'(bus.wr_en), 0);
      applyStimulus(1'b1, 5, 1'b1, 16'h5678, 1'b1);
      checkOutput("post_reset_first_write", longint'({bus.wr_en, bus.Out_Address}), longint'({1'b1, 13'd0}));

      // CONV1_1: two full planes with continuous valid.
      applyStimulus(1'b1, 2, 1'b0, 16'h0, 1'b1);
      clearStats();
      runWords(2, 2 * 6724, 1'b0);
      checkOutput("conv1_1_plane_ends", pe_cnt, 2);
      checkOutput("conv1_1_acc_never", acc_cnt, 0);
      checkOutput("conv1_1_filter", longint'(filter_cnt), 2);

      // CONV1_2: second plane of each filter accumulates.
      applyStimulus(1'b1, 3, 1'b0, 16'h0, 1'b1);
      clearStats();
      runWords(3, 6400, 1'b0);
      checkOutput("conv1_2_loop1", longint'({loop_cnt, filter_cnt}), longint'({3'd1, 5'd0}));
      checkOutput("conv1_2_first_plane_no_acc", acc_cnt, 0);
      runWords(3, 6400, 1'b0);
      checkOutput("conv1_2_second_plane_acc", acc_cnt, 6400);
      checkOutput("conv1_2_filter_step", longint'({loop_cnt, filter_cnt}), longint'({3'd0, 5'd1}));
      checkOutput("conv1_2_plane_ends", pe_cnt, 2);

      // CONV2_2 -> CONV3_1 at address 500 with valid high.
      applyStimulus(1'b1, 6, 1'b0, 16'h0, 1'b1);
      runWords(6, 500, 1'b0);
      applyStimulus(1'b1, 8, 1'b1, 16'hAAAA, 1'b1);
      checkOutput("switch_word_dropped", longint'(bus.wr_en), 0);
      applyStimulus(1'b1, 8, 1'b1, 16'h5555, 1'b1);
      checkOutput("switch_next_write",
                  longint'({bus.wr_en, bus.Out_Address, loop_cnt, filter_cnt}),
                  longint'({1'b1, 13'd0, 3'd0, 5'd0}));

`ifdef CONV_ADDR_BACKPRESSURE_EN
      runWords(8, 42, 1'b0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 8, 1'b1, 16'($urandom), 1'b0);
         checkOutput("stall_hold", longint'({bus.wr_en, bus.Out_Address}), longint'({1'b0, 13'd42}));
      end
      applyStimulus(1'b1, 8, 1'b1, 16'($urandom), 1'b1);
      checkOutput("stall_resume", longint'({bus.wr_en, bus.Out_Address}), longint'({1'b1, 13'd43}));
`endif

      // CONV3_2 full layer with valid toggling 1/0.
      applyStimulus(1'b1, 9, 1'b0, 16'h0, 1'b1);
      clearStats();
      runWords(9, 12543, 1'b1);
      applyStimulus(1'b1, 9, 1'b1, 16'h7777, 1'b1);
      checkOutput("conv3_2_done_pulse", longint'({bus.layer_done, bus.plane_end}), longint'(2'b11));
      applyStimulus(1'b1, 9, 1'b0, 16'h0, 1'b1);
      checkOutput("conv3_2_done_single", longint'(bus.layer_done), 0);
      checkOutput("conv3_2_done_count", ld_cnt, 1);
      checkOutput("conv3_2_done_word", ld_word, 12544);
      checkOutput("conv3_2_plane_ends", pe_cnt, 64);

      // Extra words after layer completion.
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b1, 9, 1'b1, 16'($urandom), 1'b1);
         checkOutput("done_no_write", longint'(bus.wr_en), 0);
      end
      checkOutput("overrun_set", longint'(err_overrun), 1);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 9, 1'b0, 16'h0, 1'b1);
         checkOutput("overrun_sticky", longint'(err_overrun), 1);
      end

      // Randomized phase checked cycle by cycle against the model.
      st_r = 9;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 399) == 0) begin
            case ($urandom_range(0, 7))
               0: st_r = 0;  1: st_r = 2;  2: st_r = 3;  3: st_r = 5;
               4: st_r = 6;  5: st_r = 8;  6: st_r = 9;  default: st_r = 7;
            endcase
         end
         applyStimulus(($urandom_range(0, 999) != 0), st_r, ($urandom_range(0, 3) != 0),
                       16'($urandom), ($urandom_range(0, 4) != 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/conv_out_addr_gen.md
# conv_out_addr_gen

Output-address generator feeding `Conv_Control` and the output feature-map buffer. Counts valid partial-sum words from the systolic-array datapath and drives `Out_Address` across each layer's output plane (0 … OUTPUT_SIZE²−1), once per input-channel loop and once per filter. Tracks loop and filter position, flags accumulate-versus-overwrite writes, and pulses layer completion back to the top-level layer FSM.

## Interface
- `DATA_WIDTH`, 16: partial-sum word width (pass-through only)
- `STATE_DATAWIDTH`, 4: top-level layer state width
- `ADDRESS_DATAWIDTH`, 13: output address width
- `LOOP_DATAWIDTH`, 3: loop counter width
- `FILTER_DATAWIDTH`, 5: filter counter width

Ports:
- `clk` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-low
- `state` in STATE_DATAWIDTH: current layer state from the top FSM
- `ps_valid` in 1: datapath presents one partial-sum word this cycle
- `ps_data` in DATA_WIDTH: partial-sum word
- `out_ready` in 1: buffer can accept a write (only with the macro, see Configuration)
- `Out_Address` out ADDRESS_DATAWIDTH: write address, registered
- `wr_en` out 1: write strobe aligned with `Out_Address`
- `wr_data` out DATA_WIDTH: registered copy of `ps_data`
- `acc_en` out 1: add to the stored value (loop ≠ 0) instead of overwriting
- `loop_cnt` out LOOP_DATAWIDTH: current loop index
- `filter_cnt` out FILTER_DATAWIDTH: current filter index
- `plane_end` out 1: one-cycle pulse on the write to address OUTPUT_SIZE²−1
- `layer_done` out 1: one-cycle pulse on the final write of the layer
- `err_overrun` out 1: sticky; `ps_valid` arrived after layer completion

## Operation
- Layer table, indexed by `state`. Each entry gives size, loops and filters:
  - CONV1_1 = 2: size 82, 1 loop, 6 filters
  - CONV1_2 = 3: size 80, 2 loops, 6 filters
  - CONV2_1 = 5: size 38, 2 loops, 16 filters
  - CONV2_2 = 6: size 36, 4 loops, 16 filters
  - CONV3_1 = 8: size 16, 4 loops, 16 filters
  - CONV3_2 = 9: size 14, 4 loops, 16 filters
  - Any other state is IDLE.
- FSM states:
  - IDLE: counters at 0, no writes.
  - RUN: entered on the first cycle `state` holds a conv value. An accepted word writes at the current address, then the address increments.
  - DONE: entered after the last write. Held until `state` changes.
- Address and counter progression:
  - Address wraps from OUTPUT_SIZE²−1 to 0 and pulses `plane_end`. The wrap increments `loop_cnt`.
  - When `loop_cnt` = loops−1 at the wrap, `loop_cnt` clears and `filter_cnt` increments.
  - When `filter_cnt` = filters−1 as well, `layer_done` pulses and the FSM enters DONE.
- `acc_en` = (`loop_cnt` ≠ 0), sampled with the write.
- Any change of `state` value, including mid-plane, clears address, loop and filter to 0 on the next edge and returns the FSM to RUN or IDLE. Partial planes are abandoned and nothing is written for them.
- `ps_valid` in IDLE or DONE: no write. In DONE it also sets `err_overrun`, which only reset clears.
- Arithmetic: OUTPUT_SIZE²−1 comes from package constants, not a multiplier. The address compare is an unsigned equality on ADDRESS_DATAWIDTH bits.

## Timing
- Reset values: `Out_Address` = 0, `wr_en` = 0, `wr_data` = 0, `acc_en` = 0, `loop_cnt` = 0, `filter_cnt` = 0, `plane_end` = 0, `layer_done` = 0, `err_overrun` = 0, FSM in IDLE.
- Latency: an accepted word appears on `wr_*` one cycle after `ps_valid`.
- Throughput: one word per cycle, back-to-back.
- `plane_end` and `layer_done` are asserted in the same cycle as the corresponding `wr_en`.
- When a `state` change and `ps_valid` occur in the same cycle, the state change wins and the word is dropped.

## Configuration
- `CONV_ADDR_BACKPRESSURE_EN` defined:
  - A word is accepted only when `ps_valid` && `out_ready`.
  - `ps_ready` out 1 is added and equals `out_ready` while in RUN.
  - With `out_ready` low, address, counters and outputs hold, and `wr_en` = 0.
- `CONV_ADDR_BACKPRESSURE_EN` undefined:
  - `out_ready` and `ps_ready` are absent.
  - Every `ps_valid` in RUN is accepted.

## Structure
- Shared package `conv_pkg` holds:
  - the layer-state constants
  - OUTPUT_SIZE per layer, and the derived last address (6723, 6399, 1443, 1295, 255, 195)
  - loops and filters per layer
  - the layer-table lookup function
  - `Conv_Control` uses the same package.
- One sub-module, `plane_counter`: an address counter with load-zero, enable and a terminal-count compare, instanced once.

## Test plan
- Reset mid-RUN (CONV2_1, address 700): `reset`=0 for one edge → all outputs 0 and FSM in IDLE on the next cycle.
- CONV1_1 with continuous `ps_valid`:
  - `plane_end` on the write at address 6723, 6 times in total.
  - `acc_en` is always 0.
  - `layer_done` coincides with the 6th plane_end, 1 cycle after the final word.
- CONV1_2:
  - Second plane of each filter has `acc_en`=1.
  - `filter_cnt` steps to 1 after two wraps at address 6399.
  - `layer_done` follows 12 planes.
- CONV3_2 with `ps_valid` toggling 1/0:
  - Addresses are contiguous 0…195 with no gaps or duplicates.
  - `layer_done` comes after 16×4×196 = 12544 words.
- `state` changes from CONV2_2 to CONV3_1 at address 500 with `ps_valid` high: the word is dropped, and the next write is at address 0 with `loop_cnt` 0 and `filter_cnt` 0.
- Two extra `ps_valid` in DONE:
  - `err_overrun` goes to 1 and stays there.
  - `wr_en` stays 0.
  - With the macro, `out_ready`=0 for 5 cycles holds `Out_Address` at 42.
